// File: rtl/instr_trace_fmt.sv
// rtl/instr_trace_fmt.sv - streaming AT&T-style ASCII formatter for decoded instruction records
// Optional PC line prefix: INSTR_TRACE_FMT_ADDR_EN
module instr_trace_fmt #(
    parameter int NUM_OPD    = 2,
    parameter int NAME_CHARS = 8,
    parameter int VAL_W      = 64,
    parameter int REG_W      = 5,
    parameter int RIMM_ID    = 31
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NAME_CHARS*8-1:0]  in_name,
    input  logic [NUM_OPD*2-1:0]     in_opd_type,
    input  logic [NUM_OPD*REG_W-1:0] in_base_reg,
    input  logic [NUM_OPD*REG_W-1:0] in_index_reg,
    input  logic [NUM_OPD*2-1:0]     in_scale,
    input  logic [NUM_OPD-1:0]       in_has_base,
    input  logic [NUM_OPD-1:0]       in_has_index,
    input  logic [NUM_OPD-1:0]       in_has_disp,
    input  logic [NUM_OPD*VAL_W-1:0] in_val,
`ifdef INSTR_TRACE_FMT_ADDR_EN
    input  logic [VAL_W-1:0]         in_pc,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_char,
    output logic                     out_last,
    output logic                     busy
);
    localparam int NIB = VAL_W / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int NMW = (NAME_CHARS > 1) ? $clog2(NAME_CHARS) : 1;

`ifdef INSTR_TRACE_FMT_ADDR_EN
    typedef enum logic [3:0] {
        IDLE, PC, NAME, TAB, OPD, SIGN, PFX0, PFXX, HEX, REG, LPAR, COMMA, RPAR, SEP, NL
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, NAME, TAB, OPD, SIGN, PFX0, PFXX, HEX, REG, LPAR, COMMA, RPAR, SEP, NL
    } state_t;
`endif

    // Which element of the current operand a SIGN/HEX or REG run (or a COMMA) belongs to
    typedef enum logic [2:0] {
        PH_RIMM, PH_RREG, PH_DISP, PH_BASE, PH_INDEX, PH_SCALE, PH_COMMA1
    } phase_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [31:0] reg_id2name(input logic [REG_W-1:0] id);
        int n;
        n = int'(id) % 100;
        case (n)
            0:       reg_id2name = {"rax", 8'h00};
            1:       reg_id2name = {"rcx", 8'h00};
            2:       reg_id2name = {"rdx", 8'h00};
            3:       reg_id2name = {"rbx", 8'h00};
            4:       reg_id2name = {"rsp", 8'h00};
            5:       reg_id2name = {"rbp", 8'h00};
            6:       reg_id2name = {"rsi", 8'h00};
            7:       reg_id2name = {"rdi", 8'h00};
            default: begin
                if (n < 10) reg_id2name = {"r", 8'(48 + n), 16'h0000};
                else        reg_id2name = {"r", 8'(48 + n / 10), 8'(48 + n % 10), 8'h00};
            end
        endcase
    endfunction

    // {found, index} of the first printable byte at or after 'from'
    function automatic logic [NMW:0] name_next(input logic [NAME_CHARS*8-1:0] nm, input int from);
        name_next = '0;
        for (int i = NAME_CHARS - 1; i >= 0; i--)
            if (i >= from && nm[(NAME_CHARS-1-i)*8 +: 8] != 8'h00) name_next = {1'b1, NMW'(i)};
    endfunction

    function automatic logic [2:0] rc_next(input logic [31:0] nm, input int from);
        rc_next = '0;
        for (int i = 3; i >= 0; i--)
            if (i >= from && nm[(3-i)*8 +: 8] != 8'h00 && nm[(3-i)*8 +: 8] != 8'h20)
                rc_next = {1'b1, 2'(i)};
    endfunction

    function automatic logic [2:0] opd_next(input logic [NUM_OPD*2-1:0] t, input int from);
        opd_next = '0;
        for (int i = NUM_OPD - 1; i >= 0; i--)
            if (i >= from && (t[i*2 +: 2] == 2'd1 || t[i*2 +: 2] == 2'd2)) opd_next = {1'b1, 2'(i)};
    endfunction

    function automatic logic [NW-1:0] top_nib(input logic [VAL_W-1:0] v);
        top_nib = '0;
        for (int i = 0; i < NIB; i++)
            if (v[i*4 +: 4] != 4'h0) top_nib = NW'(i);
    endfunction

    state_t                   state_q, state_d;
    phase_t                   ph_q, ph_d;
    logic [NAME_CHARS*8-1:0]  name_q;
    logic [NUM_OPD*2-1:0]     type_q, scale_q;
    logic [NUM_OPD*REG_W-1:0] base_q, index_q;
    logic [NUM_OPD-1:0]       hb_q, hi_q, hd_q;
    logic [NUM_OPD*VAL_W-1:0] val_q;
    logic [NMW-1:0]           name_idx_q, name_idx_d;
    logic [1:0]               opd_q, opd_d, nxt_q, nxt_d, sub_q, sub_d, rc_q, rc_d;
    logic [NW-1:0]            hex_q, hex_d;
    logic [VAL_W-1:0]         mag_q, ld_v, ld_mag;
    logic                     neg_q;
    logic [31:0]              rname_q, ld_name;
    logic [REG_W-1:0]         ld_id;
    logic                     ld_val, ld_reg, go_start, go_end, go_lpar, go_base, go_index;
    logic [1:0]               st_idx;
    logic [NMW:0]             nf;
    logic [2:0]               of, rf;
    logic                     cap, adv;
    logic [1:0]               cur_scale;
`ifdef INSTR_TRACE_FMT_ADDR_EN
    logic [VAL_W-1:0]         pc_q;
    logic [NW-1:0]            pc_idx_q, pc_idx_d;
`endif

    assign in_ready  = reset_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cap       = in_valid && in_ready;
    assign adv       = out_valid && out_ready;
    assign cur_scale = scale_q[opd_q*2 +: 2];

    always_comb begin
        state_d = state_q; ph_d = ph_q; name_idx_d = name_idx_q; opd_d = opd_q; nxt_d = nxt_q;
        sub_d = sub_q; hex_d = hex_q; rc_d = rc_q;
        ld_val = 1'b0; ld_v = '0; ld_reg = 1'b0; ld_id = '0;
        go_start = 1'b0; st_idx = '0; go_end = 1'b0; go_lpar = 1'b0; go_base = 1'b0; go_index = 1'b0;
        nf = '0; of = '0; rf = '0;
`ifdef INSTR_TRACE_FMT_ADDR_EN
        pc_idx_d = pc_idx_q;
`endif
        case (state_q)
            IDLE: if (cap) begin
`ifdef INSTR_TRACE_FMT_ADDR_EN
                state_d = PC; sub_d = 2'd0; pc_idx_d = NW'(NIB - 1);
`else
                nf = name_next(in_name, 0);
                if (nf[NMW]) begin state_d = NAME; name_idx_d = nf[NMW-1:0]; end
                else begin state_d = TAB; sub_d = 2'd0; end
`endif
            end
`ifdef INSTR_TRACE_FMT_ADDR_EN
            PC: if (adv) begin
                if (sub_q == 2'd0) begin
                    if (pc_idx_q == '0) sub_d = 2'd1;
                    else pc_idx_d = pc_idx_q - 1'b1;
                end else if (sub_q == 2'd1) begin
                    sub_d = 2'd2;
                end else begin
                    nf = name_next(name_q, 0);
                    if (nf[NMW]) begin state_d = NAME; name_idx_d = nf[NMW-1:0]; end
                    else begin state_d = TAB; sub_d = 2'd0; end
                end
            end
`endif
            NAME: if (adv) begin
                nf = name_next(name_q, int'(name_idx_q) + 1);
                if (nf[NMW]) name_idx_d = nf[NMW-1:0];
                else begin state_d = TAB; sub_d = 2'd0; end
            end
            TAB: if (adv) begin
                if (sub_q == 2'd2) begin
                    of = opd_next(type_q, 0);
                    if (of[2]) begin go_start = 1'b1; st_idx = of[1:0]; end
                    else state_d = NL;
                end else sub_d = sub_q + 1'b1;
            end
            SIGN: if (adv) state_d = PFX0;
            PFX0: if (adv) state_d = PFXX;
            PFXX: if (adv) state_d = HEX;
            HEX: if (adv) begin
                if (hex_q == '0) begin
                    case (ph_q)
                        PH_DISP:  state_d = LPAR;
                        PH_SCALE: state_d = RPAR;
                        default:  go_end = 1'b1;
                    endcase
                end else hex_d = hex_q - 1'b1;
            end
            REG: if (adv) begin
                rf = rc_next(rname_q, int'(rc_q) + 1);
                if (rf[2]) rc_d = rf[1:0];
                else begin
                    case (ph_q)
                        PH_BASE:  go_base = 1'b1;
                        PH_INDEX: go_index = 1'b1;
                        default:  go_end = 1'b1;
                    endcase
                end
            end
            LPAR: if (adv) go_lpar = 1'b1;
            COMMA: if (adv) begin
                if (ph_q == PH_SCALE) begin
                    ld_val = 1'b1; ld_v = {{(VAL_W-1){1'b0}}, 1'b1} << cur_scale;
                end else if (hi_q[opd_q]) begin
                    ld_reg = 1'b1; ld_id = index_q[opd_q*REG_W +: REG_W]; ph_d = PH_INDEX;
                end else if (cur_scale != 2'd0) begin
                    ph_d = PH_SCALE;
                end else state_d = RPAR;
            end
            RPAR: if (adv) go_end = 1'b1;
            SEP: if (adv) begin
                if (sub_q == 2'd0) sub_d = 2'd1;
                else begin go_start = 1'b1; st_idx = nxt_q; end
            end
            NL: if (adv) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Element sequencing inside a memory operand and between operands
        if (go_lpar) begin
            if (hb_q[opd_q]) begin
                ld_reg = 1'b1; ld_id = base_q[opd_q*REG_W +: REG_W]; ph_d = PH_BASE;
            end else if (hi_q[opd_q] || cur_scale != 2'd0) begin
                state_d = COMMA; ph_d = PH_COMMA1;
            end else state_d = RPAR;
        end
        if (go_base) begin
            if (hi_q[opd_q] || cur_scale != 2'd0) begin state_d = COMMA; ph_d = PH_COMMA1; end
            else state_d = RPAR;
        end
        if (go_index) begin
            if (cur_scale != 2'd0) begin state_d = COMMA; ph_d = PH_SCALE; end
            else state_d = RPAR;
        end
        if (go_end) begin
            of = opd_next(type_q, int'(opd_q) + 1);
            if (of[2]) begin state_d = SEP; sub_d = 2'd0; nxt_d = of[1:0]; end
            else state_d = NL;
        end
        if (go_start) begin
            opd_d = st_idx;
            if (type_q[st_idx*2 +: 2] == 2'd1) begin
                if (base_q[st_idx*REG_W +: REG_W] == REG_W'(RIMM_ID)) begin
                    ld_val = 1'b1; ld_v = val_q[st_idx*VAL_W +: VAL_W]; ph_d = PH_RIMM;
                end else begin
                    ld_reg = 1'b1; ld_id = base_q[st_idx*REG_W +: REG_W]; ph_d = PH_RREG;
                end
            end else if (hd_q[st_idx]) begin
                ld_val = 1'b1; ld_v = val_q[st_idx*VAL_W +: VAL_W]; ph_d = PH_DISP;
            end else state_d = LPAR;
        end

        // Magnitude as unsigned two's-complement negation; most-negative maps to itself
        ld_mag = ld_v[VAL_W-1] ? (~ld_v + 1'b1) : ld_v;
        if (ld_val) begin state_d = SIGN; hex_d = top_nib(ld_mag); end
        ld_name = reg_id2name(ld_id);
        if (ld_reg) begin
            state_d = REG;
            rf = rc_next(ld_name, 0);
            rc_d = rf[1:0];
        end
    end

    always_comb begin
        out_valid = 1'b1;
        out_char  = 8'h00;
        out_last  = 1'b0;
        case (state_q)
`ifdef INSTR_TRACE_FMT_ADDR_EN
            PC:    out_char = (sub_q == 2'd0) ? hex_char(pc_q[pc_idx_q*4 +: 4])
                            : (sub_q == 2'd1) ? 8'h3a : 8'h20;
`endif
            NAME:  out_char = name_q[(NAME_CHARS-1-name_idx_q)*8 +: 8];
            TAB:   out_char = (sub_q == 2'd2) ? 8'h09 : 8'h20;
            SIGN:  out_char = neg_q ? 8'h2d : 8'h24;
            PFX0:  out_char = 8'h30;
            PFXX:  out_char = 8'h78;
            HEX:   out_char = hex_char(mag_q[hex_q*4 +: 4]);
            REG:   out_char = rname_q[(3-rc_q)*8 +: 8];
            LPAR:  out_char = 8'h28;
            COMMA: out_char = 8'h2c;
            RPAR:  out_char = 8'h29;
            SEP:   out_char = (sub_q == 2'd0) ? 8'h2c : 8'h20;
            NL:    begin out_char = 8'h0a; out_last = 1'b1; end
            default: out_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE; ph_q <= PH_RIMM;
            name_q <= '0; type_q <= '0; scale_q <= '0; base_q <= '0; index_q <= '0;
            hb_q <= '0; hi_q <= '0; hd_q <= '0; val_q <= '0;
            name_idx_q <= '0; opd_q <= '0; nxt_q <= '0; sub_q <= '0; rc_q <= '0;
            hex_q <= '0; mag_q <= '0; neg_q <= 1'b0; rname_q <= '0;
`ifdef INSTR_TRACE_FMT_ADDR_EN
            pc_q <= '0; pc_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d; ph_q <= ph_d; name_idx_q <= name_idx_d; opd_q <= opd_d;
            nxt_q <= nxt_d; sub_q <= sub_d; hex_q <= hex_d; rc_q <= rc_d;
`ifdef INSTR_TRACE_FMT_ADDR_EN
            pc_idx_q <= pc_idx_d;
            if (cap) pc_q <= in_pc;
`endif
            if (cap) begin
                name_q <= in_name; type_q <= in_opd_type; scale_q <= in_scale;
                base_q <= in_base_reg; index_q <= in_index_reg;
                hb_q <= in_has_base; hi_q <= in_has_index; hd_q <= in_has_disp; val_q <= in_val;
            end
            if (ld_val) begin mag_q <= ld_mag; neg_q <= ld_v[VAL_W-1]; end
            if (ld_reg) rname_q <= ld_name;
        end
    end
endmodule

// File: tb/tb_instr_trace_fmt.sv
// tb/tb_instr_trace_fmt.sv - directed self-checking bench for instr_trace_fmt
module tb_instr_trace_fmt;
    localparam int NUM_OPD = 2, NAME_CHARS = 8, VAL_W = 64, REG_W = 5;

    logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last, busy;
    logic [7:0] out_char;
    logic [NAME_CHARS*8-1:0]  in_name;
    logic [NUM_OPD*2-1:0]     in_opd_type, in_scale;
    logic [NUM_OPD*REG_W-1:0] in_base_reg, in_index_reg;
    logic [NUM_OPD-1:0]       in_has_base, in_has_index, in_has_disp;
    logic [NUM_OPD*VAL_W-1:0] in_val;
`ifdef INSTR_TRACE_FMT_ADDR_EN
    logic [VAL_W-1:0]         in_pc = '0;
`endif
    int tests = 0, fails = 0;

    instr_trace_fmt #(.NUM_OPD(NUM_OPD), .NAME_CHARS(NAME_CHARS), .VAL_W(VAL_W),
                      .REG_W(REG_W), .RIMM_ID(31)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_name(in_name), .in_opd_type(in_opd_type), .in_base_reg(in_base_reg),
        .in_index_reg(in_index_reg), .in_scale(in_scale), .in_has_base(in_has_base),
        .in_has_index(in_has_index), .in_has_disp(in_has_disp), .in_val(in_val),
`ifdef INSTR_TRACE_FMT_ADDR_EN
        .in_pc(in_pc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .out_last(out_last), .busy(busy));

    always #5 clk = ~clk;

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0a)      r = {r, "\\n"};
            else if (s[i] == 8'h09) r = {r, "\\t"};
            else                    r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic check_str(input string tag, input string got, input string exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(got), vis(exp));
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        in_name = '0; in_opd_type = '0; in_scale = '0; in_base_reg = '0; in_index_reg = '0;
        in_has_base = '0; in_has_index = '0; in_has_disp = '0; in_val = '0;
    endtask

    task automatic set_name(input string s);
        in_name = '0;
        for (int i = 0; i < s.len() && i < NAME_CHARS; i++)
            in_name[(NAME_CHARS-1-i)*8 +: 8] = s[i];
    endtask

    task automatic set_reg(input int k, input logic [REG_W-1:0] id);
        in_opd_type[k*2 +: 2] = 2'd1; in_base_reg[k*REG_W +: REG_W] = id;
    endtask

    task automatic set_imm(input int k, input logic [VAL_W-1:0] v);
        in_opd_type[k*2 +: 2] = 2'd1; in_base_reg[k*REG_W +: REG_W] = 5'd31;
        in_val[k*VAL_W +: VAL_W] = v;
    endtask

    task automatic set_mem(input int k, input logic hd, input logic [VAL_W-1:0] disp,
                           input logic hb, input logic [REG_W-1:0] base,
                           input logic hi, input logic [REG_W-1:0] idx, input logic [1:0] sc);
        in_opd_type[k*2 +: 2] = 2'd2; in_has_disp[k] = hd; in_val[k*VAL_W +: VAL_W] = disp;
        in_has_base[k] = hb; in_base_reg[k*REG_W +: REG_W] = base;
        in_has_index[k] = hi; in_index_reg[k*REG_W +: REG_W] = idx; in_scale[k*2 +: 2] = sc;
    endtask

    // Called at a negedge; returns at the negedge in which the first character is valid
    task automatic send();
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clear_rec();
    endtask

    task automatic run_line(input string tag, input string exp, input bit toggle);
        string s;
        int cycles, nlast;
        bit done, stall_ok, rdy_ok, prev_stall, plast;
        logic [7:0] pch;
        s = ""; cycles = 0; nlast = 0; done = 0; stall_ok = 1; rdy_ok = 1;
        prev_stall = 0; pch = 8'h00; plast = 0;
        out_ready = 1'b1;
        send();
        for (int c = 0; c < 400 && !done; c++) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (prev_stall && (out_char !== pch || out_last !== plast)) stall_ok = 0;
            if (in_ready !== 1'b0) rdy_ok = 0;
            cycles++;
            if (out_valid && out_ready) begin
                s = $sformatf("%s%c", s, out_char);
                if (out_last) begin nlast++; done = 1; end
            end
            prev_stall = out_valid && !out_ready;
            pch = out_char; plast = out_last;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_str({tag, "_text"}, s, exp);
        check_val({tag, "_last_count"}, 64'(nlast), 64'd1);
        check_val({tag, "_busy_in_ready_low"}, 64'(rdy_ok), 64'd1);
        check_val({tag, "_in_ready_after_nl"}, 64'(in_ready), 64'd1);
        if (toggle) check_val({tag, "_stall_stable"}, 64'(stall_ok), 64'd1);
        else        check_val({tag, "_cycles"}, 64'(cycles), 64'(exp.len()));
    endtask

    initial begin
        clear_rec();
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_char", 64'(out_char), 64'h00);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

        set_name("mov"); set_reg(0, 5'd0); set_imm(1, 64'h10);
        run_line("mov_imm", "mov  \trax, $0x10\n", 1'b0);

        set_name("x"); set_imm(0, 64'hffff_ffff_ffff_ffff); set_imm(1, 64'h8000_0000_0000_0000);
        run_line("neg_imm", "x  \t-0x1, -0x8000000000000000\n", 1'b0);

        set_name("lea"); set_mem(0, 1'b1, 64'h8, 1'b1, 5'd3, 1'b1, 5'd1, 2'd2); set_reg(1, 5'd0);
        run_line("mem_full", "lea  \t$0x8(rbx,rcx,$0x4), rax\n", 1'b0);

        set_name("jmp"); set_mem(0, 1'b0, 64'h0, 1'b1, 5'd3, 1'b0, 5'd0, 2'd0);
        run_line("mem_base", "jmp  \t(rbx)\n", 1'b0);

        set_name("op"); set_reg(1, 5'd0);
        run_line("nil_first", "op  \trax\n", 1'b0);

        run_line("empty", "  \t\n", 1'b0);

        set_name("ld"); set_mem(0, 1'b1, -64'sd32, 1'b0, 5'd0, 1'b0, 5'd0, 2'd3); set_reg(1, 5'd12);
        run_line("mem_noreg", "ld  \t-0x20(,,$0x8), r12\n", 1'b0);

        set_name("nop"); in_opd_type[1:0] = 2'd3; set_imm(1, 64'h0);
        run_line("type3_zero", "nop  \t$0x0\n", 1'b0);

        set_name("mov"); set_reg(0, 5'd0); set_imm(1, 64'h10);
        run_line("mov_toggle", "mov  \trax, $0x10\n", 1'b1);

        set_name("mov"); set_reg(0, 5'd0); set_imm(1, 64'h10);
        out_ready = 1'b1;
        send();
        repeat (4) begin @(posedge clk); @(negedge clk); end
        check_val("pre_reset_char5", 64'(out_char), 64'h20);
        reset_n = 1'b0;
        #1;
        check_val("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("after_reset_in_ready", 64'(in_ready), 64'd1);

        set_name("add"); set_reg(0, 5'd2); set_imm(1, 64'hab);
        run_line("after_reset", "add  \trdx, $0xab\n", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_trace_fmt.md
# instr_trace_fmt

Streaming ASCII formatter for decoded instructions. It accepts one decoded instruction record per handshake and emits its AT&T-style text one character per cycle on a valid/ready byte stream, terminated by a newline. It sits behind the decoder's trace tap and feeds the simulation/console trace sink. It generalises the software instruction printer to a configurable operand count and value width.

## Interface

- NUM_OPD, 2: operands per record, 1..3.
- NAME_CHARS, 8: opcode-name bytes. Byte 0 is in the MSBs. NUL bytes are skipped.
- VAL_W, 64: immediate/displacement width, signed, multiple of 4.
- REG_W, 5: register id width.
- RIMM_ID, 31: base_reg value meaning "register operand is an immediate".

- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  record valid.
- in_ready  out  1  block can accept a record.
- in_name  in  NAME_CHARS*8  opcode name, ASCII.
- in_opd_type  in  NUM_OPD*2  per operand: 0 nil, 1 register, 2 memory, 3 treated as nil. Operand 0 is in the LSBs for all per-operand fields.
- in_base_reg  in  NUM_OPD*REG_W  base register, or RIMM_ID.
- in_index_reg  in  NUM_OPD*REG_W  index register.
- in_scale  in  NUM_OPD*2  log2 scale.
- in_has_base, in_has_index, in_has_disp  in  NUM_OPD each  memory-operand field flags.
- in_val  in  NUM_OPD*VAL_W  immediate (register type) or displacement (memory type).
- out_valid  out  1  character valid.
- out_ready  in  1  sink accepts character.
- out_char  out  8  ASCII character.
- out_last  out  1  high with the terminating '\n'.
- busy  out  1  record being formatted.

## Operation

- Register names come from RegMap::reg_id2name, which returns 4 characters. NUL and space characters are suppressed.
- Output order:
  - opcode name;
  - ' ', ' ', '\t';
  - each non-nil operand in index order, with ',' ' ' between consecutive printed operands;
  - '\n' (out_last=1).
- Nil operands print nothing and get no separator.
- Register operand, base_reg != RIMM_ID: the register name.
- Register operand, base_reg == RIMM_ID: signed value.
- Signed value:
  - sign character: '-' if the value is negative, else '$';
  - then "0x";
  - then the magnitude in lowercase hex with leading zeros suppressed, minimum 1 digit.
  - Magnitude is the two's-complement negation taken as unsigned VAL_W. The most-negative value prints as '-0x8' followed by VAL_W/4-1 zeros.
- Memory operand, printed in this order:
  - if has_disp: the signed displacement;
  - '(';
  - if has_base: base name;
  - if has_index or scale!=0: ',';
  - if has_index: index name (from index_reg);
  - if scale!=0: ',' then a signed value of 1<<scale;
  - ')'.
- FSM states: IDLE, NAME, TAB, OPD, SIGN, PFX0, PFXX, HEX, REG, LPAR, COMMA, RPAR, SEP, NL.
  - IDLE→NAME on capture.
  - NL→IDLE when '\n' is accepted.
  - The highest non-zero nibble index is computed when a value is loaded. HEX counts down from it to 0.
- The record is registered in full at capture. Inputs are don't-care afterwards.

## Timing

- Reset values: in_ready=0 while reset_n=0, then 1 in IDLE. out_valid=0, out_char=8'h00, out_last=0, busy=0. State is IDLE.
- in_ready = (state==IDLE). Capture happens on in_valid&&in_ready.
- First character is valid on the cycle after capture.
- With out_ready held high: exactly one character per cycle and no bubbles, including across REG/HEX sub-sequences.
- While out_valid && !out_ready, out_char and out_last are held stable.
- After the '\n' handshake, in_ready is high in the next cycle. There are no back-to-back records without a 1-cycle gap.
- An all-nil record with an empty name produces "  \t\n" (4 characters).
- When reset_n is asserted mid-record, everything clears asynchronously and the partial line is abandoned. No '\n' is emitted.

## Configuration

- INSTR_TRACE_FMT_ADDR_EN defined:
  - adds input in_pc (VAL_W bits), captured with the record;
  - each line is prefixed with the PC as VAL_W/4 hex digits, zero-padded, no "0x", followed by ':' ' ';
  - adds state PC before NAME.
- Undefined: no in_pc port, no prefix.

## Test plan

- Record name "mov", operand 0 = register id 0 (rax), operand 1 = immediate 0x10, out_ready=1 → "mov  \trax, $0x10\n". That is 17 characters on 17 consecutive cycles, out_last only on the 17th.
- Immediate -1, then immediate 0x8000000000000000 (VAL_W=64) → "-0x1" and "-0x8000000000000000".
- Memory operand: disp 0x8, base rbx(3), index rcx(1), scale 2, all flags set → "$0x8(rbx,rcx,$0x4)". Memory with only has_base, scale 0 → "(rbx)".
- Operand 0 nil, operand 1 register → "op  \trax\n" with no ", ".
- out_ready toggling 1,0,1,0… → same character sequence as the free-running case; out_char is stable on every stalled cycle; in_ready stays 0 until '\n' is accepted.
- reset_n pulsed low on the 5th character → out_valid=0 immediately, in_ready=1 after release. The next record formats correctly from its first character.
